pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core: sits beside the decode stage and decides each cycle whether the decoded instruction issues to execute, stalls, or is flushed. It tracks in-flight destination registers in a 3-entry scoreboard (EX, MEM, WB), as the datapath has no forwarding. It sequences multi-cycle flushes after taken branches/jumps and freezes everything while data memory is busy. It also keeps a stall-cycle performance counter.

## Interface
- FLUSH_CYCLES, default 2: bubble cycles inserted after an accepted redirect (range 1–7).
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- dec_valid  in  1  decode holds a valid instruction
- dec_rs1, dec_rs2  in  5 each  source register indices
- dec_rs1_used, dec_rs2_used  in  1 each  source is actually read
- dec_rd  in  5  destination index
- dec_wr  in  1  instruction writes rd
- ex_redirect  in  1  one-cycle pulse: branch taken or jump resolved in EX
- mem_busy  in  1  data memory not ready; whole pipeline must freeze
- issue  out  1  decode instruction advances into EX this cycle
- stall_fetch  out  1  hold PC and fetch/decode register
- flush_decode  out  1  replace decode register contents with NOP
- state  out  2  current FSM state (debug)
- stall_cycles  out  32  count of cycles with stall_fetch=1

## Operation
- States: RUN=0, FLUSH=1, MEM_WAIT=2 (3 unused, decodes as RUN).
- Scoreboard entries {valid, rd}: sb_ex, sb_mem, sb_wb. Shift on every non-frozen cycle: sb_wb←sb_mem, sb_mem←sb_ex, sb_ex←issue ? {dec_wr && dec_rd≠0, dec_rd} : {0,0}.
- hazard = dec_valid && ((dec_rs1_used && rs1≠0 && matches any valid entry) || same for rs2). WB entry is included (register file has no write-through).
- Per-cycle priority: reset > mem_busy > redirect (live or pending) > FLUSH countdown > hazard > issue.
- mem_busy=1: state→MEM_WAIT; issue=0, stall_fetch=1, flush_decode=0; scoreboard and flush counter hold. Leaving: first cycle with mem_busy=0 behaves as RUN (or resumes FLUSH if the counter is nonzero).
- Redirect arriving while mem_busy=1 sets redirect_pending; it is applied on the first non-busy cycle, then cleared.
- Redirect accepted: flush_decode=1, issue=0, stall_fetch=0, sb_ex shifts in invalid; counter←FLUSH_CYCLES−1; state→FLUSH if counter>0, else RUN.
- FLUSH: flush_decode=1, issue=0, counter decrements; at 0 the state returns to RUN. A redirect during FLUSH reloads the counter.
- RUN with hazard: issue=0, stall_fetch=1, flush_decode=0; a bubble enters sb_ex. Hazard clears naturally as the entry shifts out.
- RUN without hazard: issue=dec_valid, stall_fetch=0.
- stall_cycles increments by 1 each cycle stall_fetch=1, wrapping 2^32−1→0; cleared only by reset.

## Timing
- issue, stall_fetch, flush_decode are combinational from inputs plus registered state/scoreboard, with zero-cycle latency.
- Scoreboard, state, counter, pending flag, and stall_cycles update on posedge clock.
- While reset=1: issue=0, stall_fetch=0, flush_decode=1. State, scoreboard, counter, pending flag, and stall_cycles are all cleared on the clock edge; state=RUN.
- Reset mid-FLUSH or mid-MEM_WAIT discards all pending work. The first cycle after reset is plain RUN.
- Worst-case RAW stall (dependent on the immediately preceding instruction) is 3 cycles. The dependent instruction issues on the 4th cycle.
- Redirect with FLUSH_CYCLES=2: redirect cycle plus 1 FLUSH cycle = 2 flush_decode cycles.

## Structure
- The shared codes.v include gains state encodings CTRL_RUN/CTRL_FLUSH/CTRL_MEM_WAIT. Existing ZERO_REG is reused for index-0 checks.
- One sub-module, hazard_scoreboard: holds the 3 entries with shift/freeze/kill controls and outputs the combinational hazard flag. The FSM, counter, and perf counter stay in pipeline_ctrl.

## Test plan
- Back-to-back dependency: issue rd=5 write, next instruction reads rs1=5 → stall_fetch=1 for 3 cycles, issue=1 on 4th, stall_cycles=3.
- x0 and unused sources: rd=0 write, then rs1=0; and rs2=5 with rs2_used=0 → no stall.
- Redirect with FLUSH_CYCLES=2: pulse ex_redirect → flush_decode=1 for 2 cycles, issue=0, sb_ex invalid; state 0→1→0.
- Redirect during mem_busy (busy 4 cycles): no flush while busy, stall_fetch=1; flush begins the cycle busy drops.
- Redirect during FLUSH with FLUSH_CYCLES=4: counter reloads → total 4 flush cycles counted from the second redirect.
- Reset asserted mid-hazard-stall with scoreboard full → after reset, scoreboard empty, stall_cycles=0, same dependent instruction issues immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the decode-side stall/flush sequencer: FSM states,
// the zero-register index and the scoreboard entry layout.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_MEM_WAIT = 2'd2
    } ctrl_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    // A source register conflicts with an in-flight write to the same index.
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs);
        return e.valid && (e.rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_scoreboard.sv
// Three-slot (EX, MEM, WB) destination scoreboard with shift/freeze/kill
// controls and a combinational read-after-write hazard flag for decode.
module hazard_scoreboard
    import pipeline_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       advance_i,
    input  logic       kill_i,
    input  logic       wr_i,
    input  logic [4:0] rd_i,
    input  logic       dec_valid_i,
    input  logic [4:0] rs1_i,
    input  logic       rs1_used_i,
    input  logic [4:0] rs2_i,
    input  logic       rs2_used_i,
    output logic       hazard_o
);

    sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;
    sb_entry_t sb_ex_d;
    logic      rs1_hit, rs2_hit;

    always_comb begin
        sb_ex_d = '0;
        if (!kill_i) begin
            sb_ex_d.valid = wr_i && (rd_i != ZERO_REG);
            sb_ex_d.rd    = rd_i;
        end
    end

    // WB is still checked: the register file does not bypass its write port.
    always_comb begin
        rs1_hit  = rs1_used_i && (rs1_i != ZERO_REG) &&
                   (sb_match(sb_ex_q, rs1_i) || sb_match(sb_mem_q, rs1_i) ||
                    sb_match(sb_wb_q, rs1_i));
        rs2_hit  = rs2_used_i && (rs2_i != ZERO_REG) &&
                   (sb_match(sb_ex_q, rs2_i) || sb_match(sb_mem_q, rs2_i) ||
                    sb_match(sb_wb_q, rs2_i));
        hazard_o = dec_valid_i && (rs1_hit || rs2_hit);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_ex_q  <= '0;
            sb_mem_q <= '0;
            sb_wb_q  <= '0;
        end else if (advance_i) begin
            sb_wb_q  <= sb_mem_q;
            sb_mem_q <= sb_ex_q;
            sb_ex_q  <= sb_ex_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer beside decode: issues, stalls on RAW hazards, flushes
// after redirects and freezes on memory busy; counts stalled fetch cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_valid_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic        dec_rs1_used_i,
    input  logic        dec_rs2_used_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        dec_wr_i,
    input  logic        ex_redirect_i,
    input  logic        mem_busy_i,
    output logic        issue_o,
    output logic        stall_fetch_o,
    output logic        flush_decode_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        hazard;
    logic        advance;
    logic        redirect;

    hazard_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .advance_i   (advance),
        .kill_i      (!issue_o),
        .wr_i        (dec_wr_i),
        .rd_i        (dec_rd_i),
        .dec_valid_i (dec_valid_i),
        .rs1_i       (dec_rs1_i),
        .rs1_used_i  (dec_rs1_used_i),
        .rs2_i       (dec_rs2_i),
        .rs2_used_i  (dec_rs2_used_i),
        .hazard_o    (hazard)
    );

    // Decisions key on the flush counter rather than the state so that a
    // flush interrupted by mem_busy resumes once memory is ready again.
    always_comb begin
        issue_o        = 1'b0;
        stall_fetch_o  = 1'b0;
        flush_decode_o = 1'b0;
        state_d        = CTRL_RUN;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        advance        = 1'b1;
        redirect       = ex_redirect_i || pend_q;

        if (reset) begin
            flush_decode_o = 1'b1;
            advance        = 1'b0;
        end else if (mem_busy_i) begin
            state_d       = CTRL_MEM_WAIT;
            stall_fetch_o = 1'b1;
            advance       = 1'b0;
            pend_d        = pend_q || ex_redirect_i;
        end else if (redirect) begin
            flush_decode_o = 1'b1;
            cnt_d          = FLUSH_RELOAD;
            pend_d         = 1'b0;
            state_d        = (FLUSH_RELOAD != 3'd0) ? CTRL_FLUSH : CTRL_RUN;
        end else if (cnt_q != 3'd0) begin
            flush_decode_o = 1'b1;
            cnt_d          = cnt_q - 3'd1;
            state_d        = (cnt_q != 3'd1) ? CTRL_FLUSH : CTRL_RUN;
        end else if (hazard) begin
            stall_fetch_o = 1'b1;
        end else begin
            issue_o = dec_valid_i;
        end

        stall_cycles_d = stall_fetch_o ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= CTRL_RUN;
            cnt_q          <= 3'd0;
            pend_q         <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign state_o        = state_q;
    assign stall_cycles_o = stall_cycles_q;

endmodule
